// File: rtl/npm_toggle_phy_init_seq.sv
// npm_toggle_phy_init_seq: NAND Toggle PHY bring-up sequencer (reset pulse, settle, tap load, ready wait).
// Optional tap-wait abort enabled by defining PHY_INIT_TIMEOUT_EN.
module npm_toggle_phy_init_seq #(
  parameter int ResetHoldCycles = 16,
  parameter int SettleCycles    = 4,
  parameter int TapBlankCycles  = 2,
  parameter int TapLoadTimeout  = 1023
) (
  input  logic       iSystemClock,
  input  logic       iReset,
  input  logic       iNANDPowerOnEvent,
  input  logic       iStart,
  input  logic [4:0] iTapValue,
  output logic       oReady,
  output logic       oLastStep,
  output logic       oTimeout,
  output logic       oPI_Reset,
  output logic       oPI_BUFF_Reset,
  output logic       oPO_Reset,
  output logic       oPIDelayTapLoad,
  output logic [4:0] oPIDelayTap,
  input  logic       iPIDelayReady
);
  localparam int MaxA   = ResetHoldCycles > SettleCycles ? ResetHoldCycles : SettleCycles;
  localparam int MaxB   = TapLoadTimeout > TapBlankCycles ? TapLoadTimeout : TapBlankCycles;
  localparam int MaxCnt = MaxA > MaxB ? MaxA : MaxB;
  localparam int CW     = $clog2(MaxCnt + 1);
  typedef enum logic [2:0] {IDLE, RST, SETTLE, TAPLD, TAPWAIT, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic qual, tmo;
`ifdef PHY_INIT_TIMEOUT_EN
  // Counter runs TapLoadTimeout-1..0 through the wait; elapsed cycles = WaitLoad - cnt.
  localparam logic [CW-1:0] WaitLoad = CW'(TapLoadTimeout - 1);
  localparam int QualMax = TapLoadTimeout - 1 - TapBlankCycles;
  assign qual = int'(cnt) <= QualMax;
  assign tmo  = cnt == '0 && !(qual && iPIDelayReady);
`else
  // Counter only measures the blanking window and then parks at zero.
  localparam logic [CW-1:0] WaitLoad = CW'(TapBlankCycles);
  assign qual = cnt == '0;
  assign tmo  = 1'b0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = iStart ? RST : IDLE;
      RST:     nxt = cnt == '0 ? SETTLE : RST;
      SETTLE:  nxt = cnt == '0 ? TAPLD : SETTLE;
      TAPLD:   nxt = TAPWAIT;
      TAPWAIT: nxt = (qual && iPIDelayReady) || tmo ? DONE : TAPWAIT;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (iNANDPowerOnEvent) nxt = RST;
    cnt_nxt = cnt == '0 ? cnt : cnt - 1'b1;
    if (nxt != state || iNANDPowerOnEvent)
      cnt_nxt = nxt == RST ? CW'(ResetHoldCycles - 1) :
                nxt == SETTLE ? CW'(SettleCycles - 1) :
                nxt == TAPWAIT ? WaitLoad : '0;
  end
  always_ff @(posedge iSystemClock) begin
    if (!iReset) begin
      state           <= IDLE;
      cnt             <= '0;
      oPIDelayTap     <= 5'd28;
      oReady          <= 1'b1;
      oLastStep       <= 1'b0;
      oTimeout        <= 1'b0;
      oPI_Reset       <= 1'b0;
      oPI_BUFF_Reset  <= 1'b0;
      oPO_Reset       <= 1'b0;
      oPIDelayTapLoad <= 1'b0;
    end else begin
      state           <= nxt;
      cnt             <= cnt_nxt;
      oPIDelayTap     <= state == IDLE && iStart ? iTapValue : oPIDelayTap;
      oReady          <= nxt == IDLE;
      oLastStep       <= nxt == DONE;
      oTimeout        <= nxt == DONE && tmo;
      oPI_Reset       <= nxt == RST;
      oPI_BUFF_Reset  <= nxt == RST;
      oPO_Reset       <= nxt == RST;
      oPIDelayTapLoad <= nxt == TAPLD;
    end
  end
endmodule

// File: tb/tb_npm_toggle_phy_init_seq.sv
// tb_npm_toggle_phy_init_seq: directed + randomized bench against an offset-based timeline model.
module tb_npm_toggle_phy_init_seq;
  localparam int H  = 16;
  localparam int S  = 4;
  localparam int B  = 2;
  localparam int T  = 1023;
  localparam int LD = H + S + 1;
  localparam int W0 = LD + 1;
`ifdef PHY_INIT_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif
  logic clk = 1'b0, rstn = 1'b0, pon = 1'b0, start = 1'b0, rdy = 1'b0;
  logic [4:0] tapv = '0;
  logic ready, last, tout, pi_rst, pib_rst, po_rst, load;
  logic [4:0] tap;
  int passes = 0, fails = 0, total = 0;
  int cyc = 0, s = 0;
  bit busy = 1'b0, ls = 1'b0, to = 1'b0;
  logic [4:0] etap = 5'd28;

  always #5 clk = ~clk;

  npm_toggle_phy_init_seq dut (
    .iSystemClock(clk), .iReset(rstn), .iNANDPowerOnEvent(pon), .iStart(start),
    .iTapValue(tapv), .oReady(ready), .oLastStep(last), .oTimeout(tout),
    .oPI_Reset(pi_rst), .oPI_BUFF_Reset(pib_rst), .oPO_Reset(po_rst),
    .oPIDelayTapLoad(load), .oPIDelayTap(tap), .iPIDelayReady(rdy)
  );

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // Model: expected outputs follow from the cycle offset since the latest (re)start edge.
  task automatic step();
    logic p, st, r, rn;
    logic [4:0] tv;
    int d, e;
    bit q, tm, in_rst;
    p = pon; st = start; r = rdy; rn = rstn; tv = tapv;
    @(posedge clk);
    cyc++;
    #1;
    d = cyc - s;
    if (!rn) begin
      busy = 0; ls = 0; to = 0; etap = 5'd28;
    end else if (p) begin
      if (!busy && st) etap = tv;
      busy = 1; s = cyc; ls = 0; to = 0;
    end else if (!busy) begin
      if (st) begin etap = tv; busy = 1; s = cyc; end
    end else if (ls) begin
      busy = 0; ls = 0; to = 0;
    end else if (d >= W0) begin
      q  = d >= W0 + B && r;
      tm = TMO && d == W0 + T - 1;
      if (q || tm) begin ls = 1; to = !q; end
    end
    e = cyc - s + 1;
    in_rst = busy && !ls && e <= H;
    chk("ready", 5'(ready), 5'(!busy));
    chk("pi_reset", 5'(pi_rst), 5'(in_rst));
    chk("pi_buff_reset", 5'(pib_rst), 5'(in_rst));
    chk("po_reset", 5'(po_rst), 5'(in_rst));
    chk("tap_load", 5'(load), 5'(busy && !ls && e == LD));
    chk("last_step", 5'(last), 5'(ls));
    chk("timeout", 5'(tout), 5'(ls && to));
    chk("tap", tap, etap);
  endtask

  initial begin
    repeat (3) step();
    rstn = 1;
    repeat (50) step();
    tapv = 5'd9; rdy = 1; start = 1; step();
    start = 0; tapv = 0; repeat (30) step();
    tapv = 5'($urandom); rdy = 0; start = 1; step();
    start = 0; repeat (LD + 9) step();
    rdy = 1; repeat (10) step();
    tapv = 5'($urandom); rdy = 0; start = 1; step();
    start = 0; repeat (W0) step();
    pon = 1; step();
    pon = 0; rdy = 1; repeat (45) step();
    tapv = 5'd5; start = 1; step();
    start = 0; repeat (5) step();
    tapv = 5'($urandom); start = 1; step();
    start = 0; repeat (12) step();
    tapv = 5'($urandom); start = 1; step();
    start = 0; repeat (20) step();
    tapv = 5'($urandom); start = 1; step();
    start = 0; repeat (10) step();
    rstn = 0; step();
    rstn = 1; repeat (5) step();
    pon = 1; repeat (20) step();
    pon = 0; repeat (30) step();
    repeat (400) begin
      pon   = $urandom_range(0, 63) == 0;
      start = $urandom_range(0, 7) == 0;
      rdy   = 1'($urandom);
      tapv  = 5'($urandom);
      rstn  = $urandom_range(0, 199) != 0;
      step();
    end
    pon = 0; start = 0; rstn = 1; rdy = 1;
    repeat (40) step();
    rdy = 0; tapv = 5'd17; start = 1; step();
    start = 0;
    repeat (TMO ? W0 + T + 5 : 5000) step();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
